div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider executing the DIV and DIVU instructions.
- Sits in the EX stage. It is driven by the alu_control code and operands that the instruction decoder produces.
- Returns HI (remainder) and LO (quotient) to the HI/LO register path.
- Holds the pipeline via a stall output while a division runs.

Parameters:
- ALU_DIV, 5'b01010, alu_control code selecting signed division
- ALU_DIVU, 5'b01011, alu_control code selecting unsigned division
- WIDTH, 32, operand and result width; counter is $clog2(WIDTH)+1 bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  EX-stage instruction valid (not stalled by other sources)
- alu_control  input  5  operation code from the decoder
- src_a  input  WIDTH  dividend (rs)
- src_b  input  WIDTH  divisor (rt)
- flush  input  1  pipeline flush (exception/eret); aborts the current division
- stall  output  1  request to freeze IF..EX
- result_valid  output  1  one-cycle pulse: hi_o/lo_o hold a new result
- hi_o  output  WIDTH  remainder
- lo_o  output  WIDTH  quotient

Behaviour:
- Reset: state=IDLE, stall=0, result_valid=0, hi_o=0, lo_o=0, counter=0, internal regs=0.
- States: IDLE, BUSY, DONE.
- start = en & (alu_control==ALU_DIV | alu_control==ALU_DIVU) & ~flush, evaluated only in IDLE.
- stall (combinational) = start in IDLE, or state==BUSY. It is 0 in DONE and in IDLE without start.
- result_valid = (state==DONE), registered state decode.

IDLE:
- On start, latch the following and go to BUSY:
  - signed_op = (alu_control==ALU_DIV).
  - Magnitudes |src_a| and |src_b| (magnitude taken only if signed_op and the MSB is set).
  - sign_q = a_msb ^ b_msb and sign_r = a_msb, both only if signed_op.
  - Partial remainder cleared; counter=0.
- A non-div opcode with en=1 is ignored, with stall=0.

BUSY:
- One restoring step per cycle:
  - shift {rem,quo} left by 1;
  - trial = rem - divisor (WIDTH+1 bits);
  - if the trial is non-negative, rem = trial and the quotient LSB = 1.
- counter increments each step. After WIDTH steps (counter==WIDTH-1 on the edge), go to DONE and write the results:
  - lo_o = sign_q ? -quo : quo
  - hi_o = sign_r ? -rem : rem
- en and alu_control are ignored in BUSY.

DONE:
- Lasts exactly one cycle, then returns to IDLE unconditionally.
- A new div can start no earlier than the following cycle.

Latency:
- Start accepted in cycle N; BUSY occupies cycles N+1..N+WIDTH; DONE in cycle N+WIDTH+1.
- stall=1 in cycles N..N+WIDTH. result_valid=1 only in cycle N+WIDTH+1.

flush:
- In BUSY, flush returns the unit to IDLE on the next edge. No DONE, no result_valid, hi_o/lo_o unchanged, and stall drops in the cycle after flush.
- In IDLE, flush blocks start.
- In DONE, flush has no effect: the result is already written and result_valid=1; the consumer masks it.

Divide by zero (src_b==0):
- Run the full latency; no trap.
- Result: lo_o=all ones, hi_o=src_a. Sign correction is suppressed.

Signed overflow:
- 0x80000000 / 0xFFFFFFFF gives lo_o=0x80000000, hi_o=0, falling out of the natural arithmetic.

Output holding and reset:
- hi_o/lo_o hold their value until the next DONE.
- rst during BUSY or DONE overrides everything and forces the reset values on the next edge.

Test Plan:
- DIVU 100/7 (src_a=100, src_b=7, en=1 one cycle):
  - stall=1 for 33 cycles, then result_valid=1 for exactly 1 cycle;
  - hi_o=2, lo_o=14.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=0x00000001.
- DIVU 0xFFFFFFFF/0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- Divide by zero: DIV 0x12345678/0 -> after 33 cycles, lo_o=0xFFFFFFFF, hi_o=0x12345678, result_valid pulse.
- Flush and abort cases:
  - Start DIVU 100/7, assert flush in BUSY cycle 10 -> next cycle state IDLE, stall=0, no result_valid, hi_o/lo_o keep the prior values.
  - A new DIVU 9/3 then completes with lo_o=3, hi_o=0.
- Non-div opcode with en=1 -> stall=0, no activity.
- Back-to-back: en held with a div opcode -> second division starts the cycle after DONE.
- rst asserted mid-BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_unit_if.sv
// Issue/result bundle between the EX stage and the multi-cycle divider.
// The pipeline drives the master side; div_unit owns the slave side.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [4:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output en, alu_control, src_a, src_b, flush,
    input  stall, result_valid, hi_o, lo_o
  );

  modport slave (
    input  en, alu_control, src_a, src_b, flush,
    output stall, result_valid, hi_o, lo_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle.
// Returns the remainder on hi_o and the quotient on lo_o, stalling IF..EX while busy.
module div_unit #(
  parameter logic [4:0] ALU_DIV  = 5'b01010,
  parameter logic [4:0] ALU_DIVU = 5'b01011,
  parameter int         WIDTH    = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q, neg_rem_q;
  logic             valid_q;

  // Operand decode, used only on the cycle a division is accepted.
  logic             is_div, signed_op, b_zero, sign_en, a_neg, b_neg, start;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div    = (bus.alu_control == ALU_DIV) || (bus.alu_control == ALU_DIVU);
  assign signed_op = (bus.alu_control == ALU_DIV);
  assign start     = bus.en && is_div && !bus.flush && (state_q == IDLE);

  // A zero divisor runs as an unsigned divide: the restoring loop then naturally
  // yields an all-ones quotient and leaves the raw dividend as the remainder.
  assign b_zero  = (bus.src_b == '0);
  assign sign_en = signed_op && !b_zero;
  assign a_neg   = sign_en && bus.src_a[WIDTH-1];
  assign b_neg   = sign_en && bus.src_b[WIDTH-1];
  assign a_mag   = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag   = b_neg ? -bus.src_b : bus.src_b;

  // One restoring step: shift {rem,quo} left, then try subtracting the divisor.
  logic [WIDTH:0]   rem_sh, trial;
  logic             take;
  logic [WIDTH-1:0] rem_d, quo_d;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, divisor_q};
  assign take   = !trial[WIDTH];
  assign rem_d  = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_d  = {quo_q[WIDTH-2:0], take};

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, datapath included, is cleared so outputs are defined
      // straight out of reset rather than left at power-up garbage.
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            divisor_q <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              lo_q    <= neg_quo_q ? -quo_d : quo_d;
              hi_q    <= neg_rem_q ? -rem_d : rem_d;
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // stall must rise in the accept cycle itself, so it cannot wait for a register.
  assign bus.stall        = start || (state_q == BUSY);
  assign bus.result_valid = valid_q;
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected {hi,lo} pairs are queued at issue and
// compared when result_valid pulses; latency, stall, flush and reset are checked.
module tb_div_unit;
  localparam int         W       = 32;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_DIVU = 5'b01011;
  localparam logic [4:0] OP_ADD  = 5'b00000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_quiet();
    bus.en          = 1'b0;
    bus.alu_control = OP_ADD;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.flush       = 1'b0;
  endtask

  // Issues a division in the next cycle and queues the expected {hi,lo}.
  task automatic start_div(input string tag, input logic [4:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo);
    @(negedge clk);
    bus.en          = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    sb_q.push_back({ehi, elo});
    #1 check({tag, "_stall_on_accept"}, 64'(bus.stall), 64'(1));
  endtask

  // Called in the accept cycle; waits for the result pulse and scores it.
  task automatic wait_result(input string tag, input bit hold_en);
    int          stall_cycles = 1;
    int          guard        = 0;
    logic [63:0] exp;
    @(negedge clk);
    if (!hold_en) bus.en = 1'b0;
    while (!bus.result_valid && guard < 100) begin
      if (bus.stall) stall_cycles++;
      guard++;
      @(negedge clk);
    end
    check({tag, "_result_valid"}, 64'(bus.result_valid), 64'(1));
    check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(33));
    check({tag, "_stall_in_done"}, 64'(bus.stall), 64'(0));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'bx;
    check({tag, "_hi_lo"}, {bus.hi_o, bus.lo_o}, exp);
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  initial begin
    int seen;
    drive_quiet();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(bus.hi_o), 64'(0));
    check("reset_lo", 64'(bus.lo_o), 64'(0));
    check("reset_stall", 64'(bus.stall), 64'(0));
    check("reset_valid", 64'(bus.result_valid), 64'(0));
    rst = 1'b0;

    start_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_result("divu_100_7", 1'b0);
    @(negedge clk);
    check("valid_one_cycle", 64'(bus.result_valid), 64'(0));
    check("hold_after_done", {bus.hi_o, bus.lo_o}, {last_hi, last_lo});

    start_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_result("div_m7_2", 1'b0);
    start_div("div_7_m2", OP_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
    wait_result("div_7_m2", 1'b0);
    start_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
    wait_result("divu_big", 1'b0);
    start_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_result("div_ovf", 1'b0);
    start_div("div_zero", OP_DIV, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_result("div_zero", 1'b0);
    start_div("div_zero_neg", OP_DIV, 32'h8000_0005, 32'h0, 32'h8000_0005, 32'hFFFF_FFFF);
    wait_result("div_zero_neg", 1'b0);

    // Non-divide opcode with en high: no stall, no activity.
    @(negedge clk);
    bus.en = 1'b1; bus.alu_control = OP_ADD; bus.src_a = 32'd5; bus.src_b = 32'd1;
    #1 check("nondiv_stall", 64'(bus.stall), 64'(0));
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.stall || bus.result_valid) seen++;
    end
    check("nondiv_idle", 64'(seen), 64'(0));
    check("nondiv_hold", {bus.hi_o, bus.lo_o}, {last_hi, last_lo});

    // Flush in IDLE blocks the start.
    bus.alu_control = OP_DIV; bus.flush = 1'b1;
    #1 check("flush_idle_stall", 64'(bus.stall), 64'(0));
    @(negedge clk);
    bus.en = 1'b0; bus.flush = 1'b0;
    #1 check("flush_idle_no_start", 64'(bus.stall), 64'(0));

    // Flush in BUSY cycle 10 aborts without a result.
    @(negedge clk);
    bus.en = 1'b1; bus.alu_control = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    #1 check("flush_busy_stall", 64'(bus.stall), 64'(1));
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_stall_drop", 64'(bus.stall), 64'(0));
    check("flush_no_valid", 64'(bus.result_valid), 64'(0));
    check("flush_hold", {bus.hi_o, bus.lo_o}, {last_hi, last_lo});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid) seen++;
    end
    check("flush_no_late_result", 64'(seen), 64'(0));

    start_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);
    wait_result("divu_9_3", 1'b0);

    // Back-to-back: en held high; the second divide starts the cycle after DONE.
    start_div("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_result("b2b_first", 1'b1);
    bus.src_a = 32'd1000; bus.src_b = 32'd33;
    sb_q.push_back({32'd10, 32'd30});
    @(negedge clk);
    check("b2b_restart_stall", 64'(bus.stall), 64'(1));
    check("b2b_restart_valid", 64'(bus.result_valid), 64'(0));
    wait_result("b2b_second", 1'b0);

    // Reset in the middle of a division clears everything on the next edge.
    @(negedge clk);
    bus.en = 1'b1; bus.alu_control = OP_DIV; bus.src_a = 32'hFFFF_FF00; bus.src_b = 32'd3;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_hi", 64'(bus.hi_o), 64'(0));
    check("rst_busy_lo", 64'(bus.lo_o), 64'(0));
    check("rst_busy_stall", 64'(bus.stall), 64'(0));
    check("rst_busy_valid", 64'(bus.result_valid), 64'(0));
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid || bus.stall) seen++;
    end
    check("rst_busy_quiet", 64'(seen), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
